// File: rtl/sram_bus_arb2_pkg.sv
// Shared types and defaults for the two-master SRAM bus arbiter.
// Holds the bus width defaults, FSM state encoding and the tie-break helper.
package sram_bus_arb2_pkg;

   localparam int unsigned AddrWDefault = 9;
   localparam int unsigned DataWDefault = 32;
   localparam int unsigned BeWDefault   = DataWDefault / 8;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbGnt0 = 2'd1,
      ArbGnt1 = 2'd2
   } arb_state_e;

   // Round-robin pick from IDLE: on a tie the master that did not finish last wins.
   function automatic arb_state_e arb_pick(input logic req0,
                                           input logic req1,
                                           input logic last_gnt);
      arb_state_e pick;
      pick = ArbIdle;
      if (req0 && req1) begin
         pick = last_gnt ? ArbGnt0 : ArbGnt1;
      end else if (req0) begin
         pick = ArbGnt0;
      end else if (req1) begin
         pick = ArbGnt1;
      end
      return pick;
   endfunction

endpackage

// File: rtl/sram_bus_arb2.sv
// Two-master round-robin arbiter in front of sram_extern_32 on the 32-bit SRAM bus.
// One transaction per grant, with a mandatory IDLE arbitration cycle between grants.
module sram_bus_arb2
   import sram_bus_arb2_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned BE_W   = BeWDefault
) (
   input  logic              clock,
   input  logic              rst,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteena,
   input  logic [DATA_W-1:0] m0_data,
   input  logic              m0_wren,
   input  logic              m0_ce,
   output logic [DATA_W-1:0] m0_q,
   output logic              m0_wait,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteena,
   input  logic [DATA_W-1:0] m1_data,
   input  logic              m1_wren,
   input  logic              m1_ce,
   output logic [DATA_W-1:0] m1_q,
   output logic              m1_wait,

   output logic [ADDR_W-1:0] s_address,
   output logic [BE_W-1:0]   s_byteena,
   output logic [DATA_W-1:0] s_data,
   output logic              s_wren,
   output logic              s_ce,
   input  logic [DATA_W-1:0] s_q,
   input  logic              s_wait
);

   arb_state_e state_q, state_d;
   logic       last_gnt_q, last_gnt_d;

   // State register
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= ArbIdle;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      unique case (state_q)
         ArbIdle: begin
            state_d = arb_pick(m0_ce, m1_ce, last_gnt_q);
         end
         ArbGnt0: begin
            // A dropped ce is a protocol violation; abandon without touching last_gnt.
            if (!m0_ce) begin
               state_d = ArbIdle;
            end else if (!s_wait) begin
               state_d    = ArbIdle;
               last_gnt_d = 1'b0;
            end
         end
         ArbGnt1: begin
            if (!m1_ce) begin
               state_d = ArbIdle;
            end else if (!s_wait) begin
               state_d    = ArbIdle;
               last_gnt_d = 1'b1;
            end
         end
         default: begin
            state_d = ArbIdle;
         end
      endcase
   end

   // Output mux and per-master stalls
   always_comb begin
      s_address = '0;
      s_byteena = '0;
      s_data    = '0;
      s_wren    = 1'b0;
      s_ce      = 1'b0;
      unique case (state_q)
         ArbGnt0: begin
            s_address = m0_address;
            s_byteena = m0_byteena;
            s_data    = m0_data;
            s_wren    = m0_wren;
            s_ce      = m0_ce;
         end
         ArbGnt1: begin
            s_address = m1_address;
            s_byteena = m1_byteena;
            s_data    = m1_data;
            s_wren    = m1_wren;
            s_ce      = m1_ce;
         end
         default: begin
            s_ce = 1'b0;
         end
      endcase

      // s_wait is only honoured for the owner; IDLE and the loser always stall.
      m0_wait = m0_ce & ~((state_q == ArbGnt0) & ~s_wait);
      m1_wait = m1_ce & ~((state_q == ArbGnt1) & ~s_wait);
      m0_q    = s_q;
      m1_q    = s_q;
   end

endmodule
